// File: rtl/word_rotator_pkg.sv
// Shared character codes and message for the HEX character path.
// char_7seg decodes the same 2-bit codes defined here.
package word_rotator_pkg;

    localparam logic [1:0] CHAR_D     = 2'b00;
    localparam logic [1:0] CHAR_E     = 2'b01;
    localparam logic [1:0] CHAR_ONE   = 2'b10;
    localparam logic [1:0] CHAR_BLANK = 2'b11;

    // MESSAGE[i] is the i-th character of "d E 1 blank".
    localparam logic [3:0][1:0] MESSAGE = {CHAR_BLANK, CHAR_ONE, CHAR_E, CHAR_D};

    function automatic logic [1:0] mod4_add(input logic [1:0] a, input logic [1:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/word_rotator_rate_divider.sv
// Free-running rate divider: one-cycle terminal pulse every TICK_DIV enabled cycles.
// Disabling or resetting clears the count so a restart always waits a full period.
module rate_divider
    import word_rotator_pkg::*;
#(
    parameter int TICK_DIV = 50000000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Enable,
    output logic Terminal
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    assign Terminal = Enable && (count == LAST);

    always_ff @(posedge Clock) begin
        if (Reset || !Enable || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/word_rotator.sv
// Scrolls "d E 1 blank" across HEX2..HEX0 by a timed or single-stepped rotation
// offset; the three character codes decode combinationally from that offset.
module word_rotator
    import word_rotator_pkg::*;
#(
    parameter int TICK_DIV = 50000000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Enable,
    input  logic       Step,
    input  logic       Dir,
    input  logic       Load,
    input  logic [1:0] Offset_in,
    output logic [1:0] C2,
    output logic [1:0] C1,
    output logic [1:0] C0,
    output logic [1:0] Offset,
    output logic       Tick
);

    logic       term;
    logic       step_q;
    logic       step_edge;
    logic       advance;
    logic [1:0] offset_q;
    logic       tick_q;

    // A load restarts the timing period, so it clears the divider too.
    rate_divider #(.TICK_DIV(TICK_DIV)) u_div (
        .Clock    (Clock),
        .Reset    (Reset | Load),
        .Enable   (Enable),
        .Terminal (term)
    );

    assign step_edge = Step & ~step_q;
    assign advance   = Enable ? term : step_edge;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            offset_q <= 2'd0;
            tick_q   <= 1'b0;
            step_q   <= 1'b0;
        end else begin
            step_q <= Step;
            if (Load) begin
                offset_q <= Offset_in;
                tick_q   <= 1'b0;
            end else begin
                tick_q <= advance;
                if (advance) begin
                    // Scrolling right is a step of -1, i.e. +3 modulo 4.
                    offset_q <= mod4_add(offset_q, Dir ? 2'd3 : 2'd1);
                end
            end
        end
    end

    assign Offset = offset_q;
    assign Tick   = tick_q;
    assign C2     = MESSAGE[offset_q];
    assign C1     = MESSAGE[mod4_add(offset_q, 2'd1)];
    assign C0     = MESSAGE[mod4_add(offset_q, 2'd2)];

endmodule

// File: tb/tb_word_rotator.sv
// Bench for word_rotator: directed scenarios with literal expectations, then
// randomized stimulus checked every cycle against a message-rotation model.
module tb_word_rotator;

    localparam int TICK_DIV = 4;

    // ---------------- clock / reset ----------------
    logic       Clock = 1'b0;
    logic       Reset, Enable, Step, Dir, Load;
    logic [1:0] Offset_in;
    logic [1:0] C2, C1, C0, Offset;
    logic       Tick;

    logic       en1;
    logic [1:0] c2_1, c1_1, c0_1, off_1;
    logic       tick_1;

    always #5 Clock = ~Clock;

    word_rotator #(.TICK_DIV(TICK_DIV)) dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .Step(Step), .Dir(Dir),
        .Load(Load), .Offset_in(Offset_in),
        .C2(C2), .C1(C1), .C0(C0), .Offset(Offset), .Tick(Tick)
    );

    word_rotator #(.TICK_DIV(1)) dut1 (
        .Clock(Clock), .Reset(Reset), .Enable(en1), .Step(1'b0), .Dir(1'b0),
        .Load(1'b0), .Offset_in(2'd0),
        .C2(c2_1), .C1(c1_1), .C0(c0_1), .Offset(off_1), .Tick(tick_1)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The display is a 3-character window of the message string starting at the offset;
    // automatic advances happen after every TICK_DIV consecutive enabled cycles.
    string msg = "dE1_";
    int    m_off = 0;
    int    m_run = 0;
    bit    m_tick = 1'b0;
    bit    m_step_prev = 1'b0;

    function automatic logic [1:0] code_of(input byte c);
        case (c)
            "d":     return 2'b00;
            "E":     return 2'b01;
            "1":     return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    always @(posedge Clock) begin
        bit adv;
        bit rise;
        adv  = 1'b0;
        rise = Step && !m_step_prev;
        if (Reset) begin
            m_off = 0; m_run = 0; m_tick = 1'b0; m_step_prev = 1'b0;
        end else begin
            m_step_prev = Step;
            if (Load) begin
                m_off = int'(Offset_in); m_run = 0; m_tick = 1'b0;
            end else begin
                if (Enable) begin
                    m_run++;
                    adv = (m_run % TICK_DIV) == 0;
                end else begin
                    m_run = 0;
                    adv = rise;
                end
                if (adv) m_off = (m_off + (Dir ? 3 : 1)) % 4;
                m_tick = adv;
            end
        end
    end

    always @(negedge Clock) begin
        if (checking) begin
            check("offset", Offset, 2'(m_off));
            check("c2", C2, code_of(msg[m_off % 4]));
            check("c1", C1, code_of(msg[(m_off + 1) % 4]));
            check("c0", C0, code_of(msg[(m_off + 2) % 4]));
            check("tick", {1'b0, Tick}, {1'b0, m_tick});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge Clock);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        Reset = 1'b1; Enable = 1'b0; Step = 1'b0; Dir = 1'b0; Load = 1'b0;
        Offset_in = 2'd0; en1 = 1'b0;
        cyc(2);
        Reset = 1'b0;
        checking = 1'b1;
        check("rst_offset", Offset, 2'd0);
        check("rst_c2", C2, 2'b00);
        check("rst_c1", C1, 2'b01);
        check("rst_c0", C0, 2'b10);
        check("rst_tick", {1'b0, Tick}, 2'd0);
        cyc(20);
        check("idle_offset", Offset, 2'd0);

        // TICK_DIV=1 instance advances every enabled cycle
        en1 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc(1);
            check("div1_tick", {1'b0, tick_1}, 2'd1);
            check("div1_offset", off_1, 2'(k % 4));
        end
        en1 = 1'b0;

        // auto scroll left
        Enable = 1'b1; Dir = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cyc(3);
            check("auto_quiet", {1'b0, Tick}, 2'd0);
            cyc(1);
            check("auto_tick", {1'b0, Tick}, 2'd1);
            check("auto_offset", Offset, 2'(k % 4));
            if (k == 3) begin
                check("off3_c2", C2, 2'b11);
                check("off3_c1", C1, 2'b00);
                check("off3_c0", C0, 2'b01);
                check("model_off3", 2'(m_off), 2'd3);
            end
        end

        // auto scroll right
        Dir = 1'b1;
        cyc(4);
        check("right_1", Offset, 2'd3);
        cyc(4);
        check("right_2", Offset, 2'd2);

        // manual steps while paused: held Step advances once
        Enable = 1'b0; Dir = 1'b0;
        for (int r = 0; r < 2; r++) begin
            Step = 1'b1; cyc(5);
            Step = 1'b0; cyc(5);
        end
        check("step_offset", Offset, 2'd0);

        // Step edges while enabled are ignored (3 cycles, short of a period)
        Enable = 1'b1; Step = 1'b1; cyc(1);
        Step = 1'b0; cyc(1);
        Step = 1'b1; cyc(1);
        Step = 1'b0; Enable = 1'b0; cyc(2);
        check("step_ignored", Offset, 2'd0);

        // load at count=3 wins over the advance
        Enable = 1'b1; cyc(3);
        Load = 1'b1; Offset_in = 2'd2; cyc(1);
        Load = 1'b0;
        check("load_offset", Offset, 2'd2);
        check("load_tick", {1'b0, Tick}, 2'd0);
        cyc(3);
        check("post_load_quiet", {1'b0, Tick}, 2'd0);
        cyc(1);
        check("post_load_adv", Offset, 2'd3);
        check("post_load_tick", {1'b0, Tick}, 2'd1);

        // reset mid-period discards the partial count
        cyc(2);
        Reset = 1'b1; cyc(1);
        Reset = 1'b0;
        check("midrst_offset", Offset, 2'd0);
        check("midrst_tick", {1'b0, Tick}, 2'd0);
        cyc(3);
        check("midrst_quiet", {1'b0, Tick}, 2'd0);
        cyc(1);
        check("midrst_tick4", {1'b0, Tick}, 2'd1);
        check("midrst_offset4", Offset, 2'd1);

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            Reset     = ($urandom_range(0, 199) == 0);
            Load      = ($urandom_range(0, 29) == 0);
            Offset_in = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) Dir = ~Dir;
            if ($urandom_range(0, 19) == 0) Enable = ~Enable;
            if ($urandom_range(0, 3) == 0) Step = ~Step;
            cyc(1);
        end
        Reset = 1'b0; Load = 1'b0; Enable = 1'b0; Step = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
